// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch pipeline
package cpu_pkg;

    localparam int          ADDR_WIDTH = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - pipeline register with load/hold/flush and valid bit
module if_id_register #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_load,
    input  logic [31:0]           i_instruction,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus_4,
    output logic [31:0]           o_instruction,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus_4,
    output logic                  o_valid
);

    // Flush turns the stage into a bubble but leaves the PC fields alone; load beats hold
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_instruction <= NOP_INSTR;
            o_pc          <= '0;
            o_pc_plus_4   <= '0;
            o_valid       <= 1'b0;
        end else if (i_flush) begin
            o_instruction <= NOP_INSTR;
            o_valid       <= 1'b0;
        end else if (i_load) begin
            o_instruction <= i_instruction;
            o_pc          <= i_pc;
            o_pc_plus_4   <= i_pc_plus_4;
            o_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: imem handshake, PC hold, flush and IF/ID load
module instruction_fetch_unit #(
    parameter int          ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus_4,
    input  logic                  i_branch_enable,
    input  logic                  i_stall_in,
    output logic                  o_imem_read,
    output logic [ADDR_WIDTH-1:0] o_imem_address,
    input  logic [31:0]           i_imem_readdata,
    input  logic                  i_imem_busywait,
    output logic                  o_pc_hold,
    output logic [31:0]           o_if_id_instruction,
    output logic [ADDR_WIDTH-1:0] o_if_id_pc,
    output logic [ADDR_WIDTH-1:0] o_if_id_pc_plus_4,
    output logic                  o_if_id_valid
);

    import cpu_pkg::*;

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [ADDR_WIDTH-1:0] r_req_pc4;
    logic [31:0]           r_skid_instr;

    logic                  w_imem_read;
    logic [ADDR_WIDTH-1:0] w_imem_address;
    logic                  w_pc_hold;
    logic                  w_complete;
    logic                  w_load;
    logic [31:0]           w_ld_instr;
    logic [ADDR_WIDTH-1:0] w_ld_pc;
    logic [ADDR_WIDTH-1:0] w_ld_pc4;

    // Memory request and PC hold; once a request is outstanding the address comes from req_addr
    always_comb begin
        w_imem_read    = 1'b0;
        w_imem_address = i_pc;
        w_pc_hold      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_read    = !i_stall_in;
                w_imem_address = i_pc;
                w_pc_hold      = i_stall_in | i_imem_busywait;
            end
            S_WAIT, S_DROP: begin
                w_imem_read    = 1'b1;
                w_imem_address = r_req_addr;
                w_pc_hold      = 1'b1;
            end
            S_HOLD: begin
                w_imem_read    = 1'b0;
                w_imem_address = r_req_addr;
                w_pc_hold      = 1'b1;
            end
            default: begin
                w_imem_read    = 1'b0;
            end
        endcase
        if (i_reset) begin
            w_imem_read = 1'b0;
        end
    end

    assign w_complete     = w_imem_read & ~i_imem_busywait;
    assign o_imem_read    = w_imem_read;
    assign o_imem_address = w_imem_address;
    assign o_pc_hold      = w_pc_hold;

    // Select what, if anything, enters IF/ID this edge; a flush overrides any load
    always_comb begin
        w_load     = 1'b0;
        w_ld_instr = i_imem_readdata;
        w_ld_pc    = i_pc;
        w_ld_pc4   = i_pc_plus_4;
        if (!i_branch_enable) begin
            case (r_state)
                S_FETCH: begin
                    w_load = w_complete;
                end
                S_WAIT: begin
                    w_load   = w_complete & !i_stall_in;
                    w_ld_pc  = r_req_addr;
                    w_ld_pc4 = r_req_pc4;
                end
                S_HOLD: begin
                    w_load     = !i_stall_in;
                    w_ld_instr = r_skid_instr;
                    w_ld_pc    = r_req_addr;
                    w_ld_pc4   = r_req_pc4;
                end
                default: begin
                    w_load = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM: tracks outstanding requests, parks stalled data, drops wrong-path reads
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_FETCH;
            r_req_addr   <= '0;
            r_req_pc4    <= '0;
            r_skid_instr <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_imem_read && i_imem_busywait) begin
                        r_req_addr <= i_pc;
                        r_req_pc4  <= i_pc_plus_4;
                        r_state    <= i_branch_enable ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_branch_enable) begin
                        r_state <= S_DROP;
                    end else if (w_complete) begin
                        if (i_stall_in) begin
                            r_skid_instr <= i_imem_readdata;
                            r_state      <= S_HOLD;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_branch_enable || !i_stall_in) begin
                        r_state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (!i_branch_enable && w_complete) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    if_id_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_flush       (i_branch_enable),
        .i_load        (w_load),
        .i_instruction (w_ld_instr),
        .i_pc          (w_ld_pc),
        .i_pc_plus_4   (w_ld_pc4),
        .o_instruction (o_if_id_instruction),
        .o_pc          (o_if_id_pc),
        .o_pc_plus_4   (o_if_id_pc_plus_4),
        .o_valid       (o_if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        br;
    logic        stall;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        busywait;
    logic        pc_hold;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_readdata = instr_at(imem_address);

    instruction_fetch_unit dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_pc                (pc),
        .i_pc_plus_4         (pc4),
        .i_branch_enable     (br),
        .i_stall_in          (stall),
        .o_imem_read         (imem_read),
        .o_imem_address      (imem_address),
        .i_imem_readdata     (imem_readdata),
        .i_imem_busywait     (busywait),
        .o_pc_hold           (pc_hold),
        .o_if_id_instruction (ifid_instr),
        .o_if_id_pc          (ifid_pc),
        .o_if_id_pc_plus_4   (ifid_pc4),
        .o_if_id_valid       (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] a);
        pc  = a;
        pc4 = a + 32'd4;
    endtask

    // Move to the falling edge, apply inputs there; combinational checks follow #1 later
    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] a, input logic v);
        check_val({tag, "_instr"}, ifid_instr, instr_at(a));
        check_val({tag, "_pc"},    ifid_pc,    a);
        check_val({tag, "_pc4"},   ifid_pc4,   a + 32'd4);
        check_val({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, v});
    endtask

    initial begin
        rst = 1'b1; br = 1'b0; stall = 1'b0; busywait = 1'b0;
        set_pc(32'd0);
        #2;
        check_val("rst_instr", ifid_instr, NOP);
        check_val("rst_pc",    ifid_pc,    32'd0);
        check_val("rst_pc4",   ifid_pc4,   32'd0);
        check_val("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check_val("rst_read",  {31'd0, imem_read},  32'd0);

        // Zero-wait fetches at 0 and 4
        at_neg(); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i != 0) at_neg();
            set_pc(32'(i * 4));
            #1;
            check_val("zw_read", {31'd0, imem_read}, 32'd1);
            check_val("zw_addr", imem_address, 32'(i * 4));
            check_val("zw_hold", {31'd0, pc_hold}, 32'd0);
            at_pos();
            check_ifid("zw", 32'(i * 4), 1'b1);
        end

        // Busywait three cycles on pc=8; pc input is perturbed to prove address is latched
        at_neg(); set_pc(32'd8); busywait = 1'b1;
        #1;
        check_val("bw_hold0", {31'd0, pc_hold}, 32'd1);
        check_val("bw_addr0", imem_address, 32'd8);
        at_pos();
        check_val("bw_ifid_hold", ifid_pc, 32'd4);
        for (int i = 0; i < 2; i++) begin
            at_neg(); set_pc(32'h0000_0FF0);
            #1;
            check_val("bw_addr", imem_address, 32'd8);
            check_val("bw_hold", {31'd0, pc_hold}, 32'd1);
            at_pos();
        end
        at_neg(); busywait = 1'b0;
        #1;
        check_val("bw_addr_done", imem_address, 32'd8);
        at_pos();
        check_ifid("bw", 32'd8, 1'b1);

        // Stall during S_WAIT on pc=12, completion while stalled parks data in the skid buffer
        at_neg(); set_pc(32'd12); busywait = 1'b1;
        at_pos();
        at_neg(); stall = 1'b1;
        at_pos();
        check_ifid("st_wait", 32'd8, 1'b1);
        at_neg(); busywait = 1'b0;
        #1;
        check_val("st_read", {31'd0, imem_read}, 32'd1);
        check_val("st_addr", imem_address, 32'd12);
        at_pos();
        check_ifid("st_done", 32'd8, 1'b1);
        at_neg();
        #1;
        check_val("st_hold_read", {31'd0, imem_read}, 32'd0);
        check_val("st_hold_hold", {31'd0, pc_hold},   32'd1);
        at_pos();
        check_ifid("st_held", 32'd8, 1'b1);
        at_neg(); stall = 1'b0;
        at_pos();
        check_ifid("st_rel", 32'd12, 1'b1);

        // Branch with outstanding read at 16; PC redirects to 200
        at_neg(); set_pc(32'd16); busywait = 1'b1;
        at_pos();
        at_neg(); br = 1'b1;
        at_pos();
        check_val("br_valid", {31'd0, ifid_valid}, 32'd0);
        check_val("br_instr", ifid_instr, NOP);
        at_neg(); br = 1'b0; set_pc(32'd200);
        #1;
        check_val("drop_read", {31'd0, imem_read}, 32'd1);
        check_val("drop_addr", imem_address, 32'd16);
        check_val("drop_hold", {31'd0, pc_hold}, 32'd1);
        at_pos();
        at_neg(); busywait = 1'b0;
        #1;
        check_val("drop_addr2", imem_address, 32'd16);
        at_pos();
        check_val("drop_valid", {31'd0, ifid_valid}, 32'd0);
        check_val("drop_instr", ifid_instr, NOP);
        at_neg();
        #1;
        check_val("redir_addr", imem_address, 32'd200);
        check_val("redir_read", {31'd0, imem_read}, 32'd1);
        at_pos();
        check_ifid("redir", 32'd200, 1'b1);

        // Flush and stall together: flush wins
        at_neg(); set_pc(32'd204); br = 1'b1; stall = 1'b1;
        #1;
        check_val("fs_read", {31'd0, imem_read}, 32'd0);
        at_pos();
        check_val("fs_valid", {31'd0, ifid_valid}, 32'd0);
        check_val("fs_instr", ifid_instr, NOP);

        // Reload a valid entry, then reset in the middle of S_WAIT
        at_neg(); br = 1'b0; stall = 1'b0; set_pc(32'd300);
        at_pos();
        check_ifid("pre_rst", 32'd300, 1'b1);
        at_neg(); set_pc(32'd304); busywait = 1'b1;
        at_pos();
        #2; rst = 1'b1;
        #1;
        check_val("mrst_instr", ifid_instr, NOP);
        check_val("mrst_pc",    ifid_pc,    32'd0);
        check_val("mrst_pc4",   ifid_pc4,   32'd0);
        check_val("mrst_valid", {31'd0, ifid_valid}, 32'd0);
        check_val("mrst_read",  {31'd0, imem_read},  32'd0);
        at_neg(); rst = 1'b0; set_pc(32'd0); busywait = 1'b0;
        #1;
        check_val("post_rst_addr", imem_address, 32'd0);
        check_val("post_rst_read", {31'd0, imem_read}, 32'd1);
        at_pos();
        check_ifid("post_rst", 32'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF-stage consumer of the `program_counter` outputs (`pc`, `pc_plus_4`).
- Issues reads to instruction memory over a read/busywait handshake and loads the IF/ID pipeline register.
- Drives `pc_hold` back to `program_counter` so the PC freezes during memory waits and decode stalls.
- Treats `branch_enable` (same signal that redirects the PC) as a flush, discarding wrong-path fetches including in-flight ones.

Parameters:
- NOP_INSTR, 32'h00000013, bubble value loaded into `if_id_instruction` (addi x0,x0,0).
- ADDR_WIDTH, 32, PC / instruction address width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- pc  input  ADDR_WIDTH  current PC from program_counter.
- pc_plus_4  input  ADDR_WIDTH  pc+4 from program_counter.
- branch_enable  input  1  taken branch/jump; flushes IF/ID and any outstanding fetch.
- stall_in  input  1  decode/hazard stall; IF/ID must hold.
- imem_read  output  1  read request to instruction memory.
- imem_address  output  ADDR_WIDTH  read address; stable while imem_read && imem_busywait.
- imem_readdata  input  32  instruction; valid in the cycle imem_read=1 and imem_busywait=0.
- imem_busywait  input  1  memory not ready; may respond combinationally (hit).
- pc_hold  output  1  1 = program_counter must not advance this edge (branch load still wins).
- if_id_instruction  output  32  IF/ID instruction.
- if_id_pc  output  ADDR_WIDTH  IF/ID PC.
- if_id_pc_plus_4  output  ADDR_WIDTH  IF/ID PC+4.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, immediate):
  - state=S_FETCH; if_id_instruction=NOP_INSTR; if_id_pc=0; if_id_pc_plus_4=0; if_id_valid=0.
  - Skid buffer cleared; req_addr=0; imem_read=0 while reset is high.
- Priority at each edge: reset > branch_enable > stall_in > normal.
- Fetch completes in a cycle where imem_read=1 and imem_busywait=0.
- States:
  - S_FETCH:
    - imem_read=!stall_in; imem_address=pc; pc_hold=stall_in|imem_busywait.
    - Completion, no stall/flush: IF/ID <= {imem_readdata, pc, pc_plus_4}, valid=1; stay S_FETCH. A zero-wait hit gives 1-cycle latency and one instruction per cycle.
    - busywait=1: req_addr<=pc, req_pc4<=pc_plus_4; go S_WAIT.
    - stall_in=1: no request; IF/ID holds.
  - S_WAIT:
    - imem_read=1; imem_address=req_addr; pc_hold=1.
    - On completion: if !stall_in, load IF/ID from req_addr/req_pc4 and go S_FETCH; else store in skid buffer and go S_HOLD.
  - S_HOLD:
    - imem_read=0; pc_hold=1.
    - When stall_in=0: IF/ID <= skid buffer, valid=1; go S_FETCH.
  - S_DROP:
    - imem_read=1; imem_address=req_addr; pc_hold=1.
    - On completion: discard data, if_id_valid stays 0; go S_FETCH.
- Flush (branch_enable=1 at edge):
  - if_id_valid<=0 and if_id_instruction<=NOP_INSTR, regardless of stall_in.
  - S_FETCH with busywait=1: capture req_addr, go S_DROP.
  - S_WAIT: go S_DROP.
  - S_FETCH with completion, or S_HOLD: data/buffer discarded; go S_FETCH.
  - S_DROP: stays S_DROP.
  - branch_enable during S_DROP: stay S_DROP, IF/ID stays bubble.
- Stall with valid IF/ID: IF/ID unchanged, no new request issued from S_FETCH.
- Address never changes mid-request: in S_WAIT/S_DROP it comes from req_addr, not pc.
- Width rules:
  - pc_plus_4 passes through unmodified; no arithmetic in this block.
  - No alignment checks; pc[1:0] forwarded as-is.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding typedef {S_FETCH, S_WAIT, S_HOLD, S_DROP}.
  - NOP_INSTR constant.
  - ADDR_WIDTH.
- One natural sub-module: if_id_register (load/hold/flush pipeline register with valid bit), reused by the later ID/EX stage style.
- FSM and skid buffer stay in the top.

Test Plan:
- Reset pulse mid-S_WAIT -> outputs immediately NOP_INSTR/0/valid=0, imem_read=0; after release, first fetch at pc=0.
- Zero-wait memory, pc 0,4,8 -> IF/ID shows (instr@0, pc=0, pc4=4) one edge after each request; pc_hold=0 throughout.
- Busywait 3 cycles on pc=8 -> imem_address=8 stable, pc_hold=1 for 3 cycles; IF/ID loads instr@8 on the completing edge.
- stall_in=1 during S_WAIT on pc=12, completion while stalled -> IF/ID unchanged; S_HOLD; after stall drops, IF/ID=instr@12 one edge later.
- branch_enable=1 with outstanding read at pc=16 (busywait 2 more cycles), PC loads 200 -> if_id_valid=0; read for 16 held until done and discarded; next request address 200.
- branch_enable and stall_in both 1 in same cycle -> flush wins: if_id_valid=0, if_id_instruction=NOP_INSTR.
